// File: rtl/edge_pulse_gen_pkg.sv
// Shared types and defaults for the edge-signalling pulse generator.
package edge_pulse_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } epg_state_e;

    localparam int unsigned DEFAULT_WIDTH_W = 8;
    localparam int unsigned DEFAULT_GAP     = 2;

endpackage : edge_pulse_gen_pkg

// File: rtl/edge_pulse_gen.sv
// Transmit end of the edge-signalling interface: one programmable-width high
// pulse per accepted request, followed by an enforced low gap.
// Optional feature macro: EDGE_PULSE_GEN_RETRIGGER_EN (accept during HIGH
// extends the current pulse instead of waiting for IDLE).
module edge_pulse_gen
    import edge_pulse_gen_pkg::*;
#(
    parameter int unsigned WIDTH_W    = DEFAULT_WIDTH_W,
    parameter int unsigned GAP_CYCLES = DEFAULT_GAP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH_W-1:0] req_width,
    output logic               sig_o,
    output logic               busy,
    output logic               fall_strb
);

    epg_state_e         state_q, state_d;
    logic [WIDTH_W-1:0] cnt_q, cnt_d;
    logic               sig_d, busy_d, fall_d;
    logic               accept;
    logic [WIDTH_W-1:0] load_cnt;
    logic [WIDTH_W-1:0] gap_load;

    // Width 0 behaves as width 1; counter holds remaining cycles minus one.
    assign load_cnt = (req_width == '0) ? '0 : req_width - WIDTH_W'(1);
    assign gap_load = WIDTH_W'(GAP_CYCLES - 1);
    assign accept   = req_valid && req_ready;

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sig_o     <= 1'b0;
            busy      <= 1'b0;
            fall_strb <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sig_o     <= sig_d;
            busy      <= busy_d;
            fall_strb <= fall_d;
        end
    end

    // Next-state and down-counter; counter only loads or decrements towards 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = HIGH;
                    cnt_d   = load_cnt;
                end
            end
            HIGH: begin
`ifdef EDGE_PULSE_GEN_RETRIGGER_EN
                if (accept) begin
                    cnt_d = load_cnt;
                end else
`endif
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = gap_load;
                end else begin
                    cnt_d = cnt_q - WIDTH_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - WIDTH_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Ready decode and next values of the registered outputs.
    always_comb begin
        req_ready = 1'b0;
        sig_d     = 1'b0;
        busy_d    = 1'b0;
        fall_d    = 1'b0;
`ifdef EDGE_PULSE_GEN_RETRIGGER_EN
        req_ready = (state_q == IDLE) || (state_q == HIGH);
`else
        req_ready = (state_q == IDLE);
`endif
        sig_d     = (state_d == HIGH);
        busy_d    = (state_d != IDLE);
        fall_d    = (state_q == HIGH) && (state_d == GAP);
    end

endmodule : edge_pulse_gen

// File: tb/tb_edge_pulse_gen.sv
// Directed bench for edge_pulse_gen with a registered falling-edge receiver
// and a scoreboard of expected pulse widths.
module tb_edge_pulse_gen;
    import edge_pulse_gen_pkg::*;

    localparam int unsigned WW  = DEFAULT_WIDTH_W;
    localparam int unsigned GAP = DEFAULT_GAP;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          req_valid = 1'b0;
    logic [WW-1:0] req_width = '0;
    logic          req_ready, sig_o, busy, fall_strb;

    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int acc_cyc   = 0;
    int falls     = 0;
    int rx_edges  = 0;
    int exp_falls = 0;
    int sb[$];

    edge_pulse_gen #(.WIDTH_W(WW), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_width (req_width),
        .sig_o     (sig_o),
        .busy      (busy),
        .fall_strb (fall_strb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiving end: registered falling-edge detector.
    logic rx_q, rx_edge;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_q    <= 1'b0;
            rx_edge <= 1'b0;
        end else begin
            rx_q    <= sig_o;
            rx_edge <= rx_q & ~sig_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor: measure each high run and compare against the scoreboard at the fall.
    int   run     = 0;
    logic prev_sig = 1'b0;
    logic prev_fs  = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            run      = 0;
            prev_sig = 1'b0;
            prev_fs  = 1'b0;
        end else begin
            if (prev_fs) check("rx_edge_after_fall_strb", 32'(rx_edge), 1);
            if (rx_edge) rx_edges++;
            if (sig_o) begin
                run++;
            end else if (prev_sig) begin
                falls++;
                check("fall_strb_at_fall", 32'(fall_strb), 1);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_pulse: observed width %0d expected no pulse", run);
                end else begin
                    check("pulse_width", 32'(run), 32'(sb.pop_front()));
                end
                run = 0;
            end else begin
                check("no_stray_fall_strb", 32'(fall_strb), 0);
            end
            prev_sig = sig_o;
            prev_fs  = fall_strb;
        end
    end

    // Present a request; returns #1 after the accepting edge.
    task automatic send(input logic [WW-1:0] w, input bit hold);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_width = w;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed req_ready 0 expected 1");
            req_valid = 1'b0;
        end else begin
            sb.push_back((w == 0) ? 1 : int'(w));
            exp_falls++;
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            if (!hold) req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || !req_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(busy || !req_ready), 0);
    endtask

    initial begin
        int n;
        int prev_acc;
        int f0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_sig_o", 32'(sig_o), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_fall_strb", 32'(fall_strb), 0);
        check("rst_req_ready", 32'(req_ready), 1);
        #1 rst_n = 1'b1;

        // Reset mid-pulse: width 10, fourth high cycle
        send(8'd10, 1'b0);
        repeat (4) @(negedge clk);
        check("pre_rst_sig_o", 32'(sig_o), 1);
        check("pre_rst_busy", 32'(busy), 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_sig_o", 32'(sig_o), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_fall_strb", 32'(fall_strb), 0);
        check("async_rst_req_ready", 32'(req_ready), 1);
        void'(sb.pop_front());
        exp_falls--;
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Single width 3: fall_strb W cycles after accept, ready after W+GAP
        send(8'd3, 1'b0);
        check("single_busy", 32'(busy), 1);
        check("single_sig_rise", 32'(sig_o), 1);
        n = 0;
        @(negedge clk);
        while (!fall_strb && n < 100) begin @(negedge clk); n++; end
        check("single_fall_latency", 32'(cyc - acc_cyc), 3);
        n = 0;
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        check("single_ready_latency", 32'(cyc - acc_cyc), 3 + GAP);
        check("single_busy_done", 32'(busy), 0);

        // Width 0 behaves as width 1
        send(8'd0, 1'b0);
        wait_idle();

        // Back-to-back with req_valid held: accepts spaced W+GAP+1 apart
        send(8'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            prev_acc = acc_cyc;
            send(8'd2, 1'b1);
            check("b2b_spacing", 32'(acc_cyc - prev_acc), 2 + GAP + 1);
        end
        req_valid = 1'b0;
        wait_idle();

        // Maximum width, no counter wrap
        send(8'd255, 1'b0);
        wait_idle();

        // Re-request during the second high cycle
        f0 = falls;
        send(8'd4, 1'b0);
        repeat (2) @(negedge clk);
        req_valid = 1'b1;
        req_width = 8'd4;
`ifdef EDGE_PULSE_GEN_RETRIGGER_EN
        @(posedge clk);
        #1 req_valid = 1'b0;
        sb[sb.size() - 1] = 6;
        wait_idle();
        check("retrigger_fall_count", 32'(falls - f0), 1);
`else
        send(8'd4, 1'b0);
        wait_idle();
        check("no_retrigger_fall_count", 32'(falls - f0), 2);
`endif

        // Drain and totals
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);
        check("fall_count", 32'(falls), 32'(exp_falls));
        check("rx_edge_count", 32'(rx_edges), 32'(falls));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_edge_pulse_gen
